// File: rtl/fractal_sync_node_if.sv
// Sync/wake handshake bundle between a fractal sync requester (master) and a barrier node (slave).
// N lanes share one bundle: two for the child side of a node, one for its parent side.
interface fractal_sync_node_if #(
  parameter int unsigned N     = 2,
  parameter int unsigned LVL_W = 3
);
  logic [N-1:0]            sync;
  logic [N-1:0][LVL_W-1:0] level;
  logic [N-1:0]            ack;
  logic [N-1:0]            wake;
  logic [N-1:0]            error;

  modport master (output sync, level, ack, input wake, error);
  modport slave  (input sync, level, ack, output wake, error);
endinterface

// File: rtl/fractal_sync_node.sv
// Two-child barrier node of the fractal sync tree: releases both children locally at its own
// level, otherwise forwards one aggregated request upward and releases on the parent's wake.
module fractal_sync_node #(
  parameter int unsigned LVL_W    = 3,
  parameter int unsigned NODE_LVL = 1,
  parameter bit          TOP      = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  fractal_sync_node_if.slave  c_if,
  fractal_sync_node_if.master p_if,
  output logic                proto_err_o
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_UP_REQ  = 3'd1;
  localparam logic [2:0] ST_UP_WAIT = 3'd2;
  localparam logic [2:0] ST_WAKE    = 3'd3;
  localparam logic [2:0] ST_UP_ACK  = 3'd4;

  localparam logic [LVL_W-1:0] NODE_LVL_V = LVL_W'(NODE_LVL);

  logic [2:0]            state_q, state_d;
  logic [1:0]            pend_q, pend_d;
  logic [1:0]            acked_q, acked_d;
  logic [1:0][LVL_W-1:0] lvl_q, lvl_d;
  logic                  err_q, err_d;
  logic                  up_q, up_d;
  logic                  proto_err_q, proto_err_d;

  logic [1:0] wake_vec;
  logic       p_sync;
  logic       p_wake;
  logic       p_error;
  logic       bad_lvl;

  // A root node has no parent, so its parent inputs are masked off entirely.
  assign p_wake  = !TOP && p_if.wake[0];
  assign p_error = p_if.error[0];

  assign bad_lvl = (lvl_q[0] != lvl_q[1]) || (lvl_q[0] == '0) ||
                   (lvl_q[0] < NODE_LVL_V) || ((lvl_q[0] > NODE_LVL_V) && TOP);

  assign wake_vec = (state_q == ST_WAKE) ? ~acked_q : 2'b00;
  assign p_sync   = !TOP && (state_q == ST_UP_REQ);

  assign c_if.wake     = wake_vec;
  assign c_if.error    = wake_vec & {2{err_q}};
  assign p_if.sync[0]  = p_sync;
  assign p_if.level[0] = p_sync ? lvl_q[0] : '0;
  assign p_if.ack[0]   = !TOP && (state_q == ST_UP_ACK);
  assign proto_err_o   = proto_err_q;

  always_comb begin
    // NOTE: every _d starts from its held value, so no branch can leave one unassigned and infer a latch.
    state_d     = state_q;
    pend_d      = pend_q;
    lvl_d       = lvl_q;
    acked_d     = acked_q;
    err_d       = err_q;
    up_d        = up_q;
    proto_err_d = proto_err_q;

    for (int k = 0; k < 2; k++) begin
      if (c_if.sync[k]) begin
        if (state_q != ST_IDLE || pend_q[k]) proto_err_d = 1'b1;
        else begin
          pend_d[k] = 1'b1;
          lvl_d[k]  = c_if.level[k];
        end
      end
      if (c_if.ack[k]) begin
        if (!wake_vec[k]) proto_err_d = 1'b1;
        else              acked_d[k]  = 1'b1;
      end
    end
    if (p_wake && state_q != ST_UP_WAIT) proto_err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (pend_q == 2'b11) begin
          if (bad_lvl) begin
            err_d   = 1'b1;
            up_d    = 1'b0;
            state_d = ST_WAKE;
          end else if (lvl_q[0] == NODE_LVL_V) begin
            err_d   = 1'b0;
            up_d    = 1'b0;
            state_d = ST_WAKE;
          end else begin
            up_d    = 1'b1;
            state_d = ST_UP_REQ;
          end
        end
      end
      ST_UP_REQ: state_d = ST_UP_WAIT;
      ST_UP_WAIT: begin
        if (p_wake) begin
          err_d   = p_error;
          state_d = ST_WAKE;
        end
      end
      ST_WAKE: begin
        // Acks of this very cycle count, so the node leaves WAKE on the edge after the last ack.
        if (acked_d == 2'b11) begin
          pend_d  = 2'b00;
          acked_d = 2'b00;
          err_d   = 1'b0;
          up_d    = 1'b0;
          state_d = up_q ? ST_UP_ACK : ST_IDLE;
        end
      end
      ST_UP_ACK: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
    if (rst_i) begin
      state_q     <= ST_IDLE;
      pend_q      <= 2'b00;
      acked_q     <= 2'b00;
      lvl_q       <= '0;
      err_q       <= 1'b0;
      up_q        <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      acked_q     <= acked_d;
      lvl_q       <= lvl_d;
      err_q       <= err_d;
      up_q        <= up_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_fractal_sync_node.sv
// Bench for fractal_sync_node: timestamp-based barrier model checked every cycle, directed
// scenarios with literal expectations, then randomized child/parent traffic with rare violations.
module tb_fractal_sync_node;
  localparam int unsigned LVL_W = 3;
  localparam int          NODE  = 1;
  localparam int          INF   = 32'h3fff_ffff;

  logic clk = 1'b0;
  logic rst;
  logic perr, perr_t;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fractal_sync_node_if #(.N(2), .LVL_W(LVL_W)) c_if ();
  fractal_sync_node_if #(.N(1), .LVL_W(LVL_W)) p_if ();
  fractal_sync_node_if #(.N(2), .LVL_W(LVL_W)) ct_if ();
  fractal_sync_node_if #(.N(1), .LVL_W(LVL_W)) pt_if ();

  fractal_sync_node #(.LVL_W(LVL_W), .NODE_LVL(NODE), .TOP(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .c_if(c_if.slave), .p_if(p_if.master), .proto_err_o(perr));

  fractal_sync_node #(.LVL_W(LVL_W), .NODE_LVL(NODE), .TOP(1'b1)) dut_t (
    .clk_i(clk), .rst_i(rst), .c_if(ct_if.slave), .p_if(pt_if.master), .proto_err_o(perr_t));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: a barrier is described by the cycles at which its visible events happen.
  bit         m_on = 1'b0;
  bit         m_pend [2];
  logic [2:0] m_lv [2];
  bit         m_busy, m_up, m_err, m_perr, m_done;
  int         m_wake_from, m_psync_at, m_wait_from, m_pack_at, m_idle_at;
  int         m_wake_end [2];

  function automatic bit m_wake(input int k, input int c);
    return (c >= m_wake_from) && (c < m_wake_end[k]);
  endfunction

  task automatic m_clear();
    m_pend = '{1'b0, 1'b0};
    m_lv = '{3'd0, 3'd0};
    m_busy = 1'b0; m_up = 1'b0; m_err = 1'b0; m_perr = 1'b0; m_done = 1'b0;
    m_wake_from = INF; m_psync_at = INF; m_wait_from = INF; m_pack_at = INF; m_idle_at = 0;
    m_wake_end = '{INF, INF};
  endtask

  task automatic m_update();
    bit illegal;
    if (rst) begin
      m_on = 1'b1;
      m_clear();
      return;
    end
    if (!m_on) return;
    if (m_busy && cyc >= m_idle_at) m_busy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (c_if.sync[k]) begin
        if (m_busy || m_pend[k]) m_perr = 1'b1;
        else begin
          m_pend[k] = 1'b1;
          m_lv[k] = c_if.level[k];
        end
      end
      if (c_if.ack[k]) begin
        if (m_wake(k, cyc)) m_wake_end[k] = cyc + 1;
        else m_perr = 1'b1;
      end
    end
    if (m_busy && !m_done && m_wake_end[0] != INF && m_wake_end[1] != INF) begin
      m_done = 1'b1;
      m_pend = '{1'b0, 1'b0};
      if (m_up) begin
        m_pack_at = cyc + 1;
        m_idle_at = cyc + 2;
      end else m_idle_at = cyc + 1;
    end
    if (p_if.wake[0]) begin
      if (m_busy && m_up && cyc >= m_wait_from && m_wake_from == INF) begin
        m_wake_from = cyc + 1;
        m_err = p_if.error[0];
      end else m_perr = 1'b1;
    end
    if (!m_busy && m_pend[0] && m_pend[1]) begin
      illegal = (m_lv[0] != m_lv[1]) || (m_lv[0] == 3'd0) || (int'(m_lv[0]) < NODE);
      m_busy = 1'b1; m_done = 1'b0;
      m_wake_end = '{INF, INF};
      m_pack_at = INF; m_idle_at = INF;
      if (illegal || int'(m_lv[0]) == NODE) begin
        m_up = 1'b0; m_err = illegal;
        m_wake_from = cyc + 2; m_psync_at = INF; m_wait_from = INF;
      end else begin
        m_up = 1'b1;
        m_psync_at = cyc + 2; m_wait_from = cyc + 3; m_wake_from = INF;
      end
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] exp_w;
    if (m_on) begin
      exp_w = {m_wake(1, cyc), m_wake(0, cyc)};
      check("c_wake", 32'(c_if.wake), 32'(exp_w));
      check("c_error", 32'(c_if.error), 32'(exp_w & {2{m_err}}));
      check("p_sync", 32'(p_if.sync), 32'(cyc == m_psync_at));
      check("p_level", 32'(p_if.level), 32'((cyc == m_psync_at) ? m_lv[0] : 3'd0));
      check("p_ack", 32'(p_if.ack), 32'(cyc == m_pack_at));
      check("proto_err", 32'(perr), 32'(m_perr));
    end
    m_update();
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rst = 1'b0;
    c_if.sync = '0;  c_if.ack = '0;  p_if.wake = '0;  p_if.error = '0;
    ct_if.sync = '0; ct_if.ack = '0; pt_if.wake = '0; pt_if.error = '0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic csync(input int k, input int lv);
    c_if.sync[k] = 1'b1;
    c_if.level[k] = 3'(lv);
  endtask

  initial begin
    bit synced [2];
    int upcnt;
    rst = 1'b1;
    c_if.sync = '0;  c_if.ack = '0;  c_if.level = '0;  p_if.wake = '0;  p_if.error = '0;
    ct_if.sync = '0; ct_if.ack = '0; ct_if.level = '0; pt_if.wake = '0; pt_if.error = '0;
    repeat (3) begin @(posedge clk); #1; end
    tick();
    check("reset_wake", 32'(c_if.wake), 0);
    check("reset_perr", 32'(perr), 0);

    // Local barrier, later sync at b+5.
    ticks(4); csync(0, 1);
    ticks(5); csync(1, 1);
    tick(); check("local_wake_early", 32'(c_if.wake), 0);
    tick(); check("local_wake", 32'(c_if.wake), 32'h3);
    check("local_err", 32'(c_if.error), 0);
    check("local_psync", 32'(p_if.sync), 0);
    tick(); c_if.ack = 2'b11;
    tick(); check("local_wake_drop", 32'(c_if.wake), 0);

    // Simultaneous up request, staggered acks.
    ticks(2); csync(0, 2); csync(1, 2);
    ticks(2); check("up_psync", 32'(p_if.sync), 1);
    check("up_plevel", 32'(p_if.level), 2);
    tick(); check("up_psync_once", 32'(p_if.sync), 0);
    check("up_plevel_zero", 32'(p_if.level), 0);
    ticks(4); p_if.wake = 1'b1;
    tick(); check("up_wake", 32'(c_if.wake), 32'h3);
    tick(); c_if.ack = 2'b01;
    tick(); check("up_wake_10", 32'(c_if.wake), 32'h2);
    tick(); c_if.ack = 2'b10;
    tick(); check("up_wake_00", 32'(c_if.wake), 0);
    check("up_pack", 32'(p_if.ack), 1);
    tick(); check("up_pack_once", 32'(p_if.ack), 0);

    // Parent error propagation at level 3.
    tick(); csync(0, 3); csync(1, 3);
    ticks(2); check("perr_plevel", 32'(p_if.level), 3);
    ticks(2); p_if.wake = 1'b1; p_if.error = 1'b1;
    tick(); check("perr_cerr", 32'(c_if.error), 32'h3);
    c_if.ack = 2'b01;
    tick(); check("perr_cerr_10", 32'(c_if.error), 32'h2);
    c_if.ack = 2'b10;
    tick(); check("perr_cerr_clr", 32'(c_if.error), 0);
    check("perr_pack", 32'(p_if.ack), 1);

    // Illegal levels: mismatch on the inner node, level 2 on the root node.
    ticks(2); csync(0, 1); csync(1, 2);
    ct_if.sync = 2'b11; ct_if.level[0] = 3'd2; ct_if.level[1] = 3'd2;
    tick(); pt_if.wake = 1'b1; pt_if.error = 1'b1;
    tick(); check("mis_wake", 32'(c_if.wake), 32'h3);
    check("mis_err", 32'(c_if.error), 32'h3);
    check("mis_psync", 32'(p_if.sync), 0);
    check("top_wake", 32'(ct_if.wake), 32'h3);
    check("top_err", 32'(ct_if.error), 32'h3);
    check("top_psync", 32'(pt_if.sync), 0);
    c_if.ack = 2'b11; ct_if.ack = 2'b11;
    tick(); check("mis_wake_drop", 32'(c_if.wake), 0);
    check("top_perr_ignored", 32'(perr_t), 0);
    csync(0, 0); csync(1, 0);
    ct_if.sync = 2'b11; ct_if.level[0] = 3'd1; ct_if.level[1] = 3'd1;
    ticks(2); check("zero_err", 32'(c_if.error), 32'h3);
    check("top_local_err", 32'(ct_if.error), 0);
    check("top_local_wake", 32'(ct_if.wake), 32'h3);
    c_if.ack = 2'b11; ct_if.ack = 2'b11;

    // Protocol violations: spurious ack, then a double sync before a normal barrier.
    ticks(2); check("pv_before", 32'(perr), 0);
    c_if.ack[1] = 1'b1;
    tick(); check("pv_spur_ack", 32'(perr), 1);
    rst = 1'b1;
    tick(); check("pv_cleared", 32'(perr), 0);
    csync(0, 1);
    ticks(2); csync(0, 1);
    tick(); check("pv_double_sync", 32'(perr), 1);
    tick(); csync(1, 1);
    ticks(2); check("pv_barrier_wake", 32'(c_if.wake), 32'h3);
    check("pv_barrier_err", 32'(c_if.error), 0);
    c_if.ack = 2'b11;
    tick(); check("pv_sticky", 32'(perr), 1);

    // Reset in UP_WAIT, then a late parent wake, then a fresh barrier.
    tick(); csync(0, 2); csync(1, 2);
    ticks(4); rst = 1'b1;
    tick(); check("rst_wake", 32'(c_if.wake), 0);
    check("rst_psync", 32'(p_if.sync), 0);
    check("rst_pack", 32'(p_if.ack), 0);
    check("rst_perr", 32'(perr), 0);
    tick(); p_if.wake = 1'b1;
    tick(); check("rst_late_wake", 32'(c_if.wake), 0);
    check("rst_late_perr", 32'(perr), 1);
    csync(0, 1); csync(1, 1);
    ticks(2); check("rst_fresh_wake", 32'(c_if.wake), 32'h3);
    c_if.ack = 2'b11;
    tick(); rst = 1'b1;

    // Randomized traffic; the per-cycle model comparison does the checking.
    synced = '{1'b0, 1'b0};
    upcnt = -1;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        synced = '{1'b0, 1'b0};
        upcnt = -1;
        continue;
      end
      for (int k = 0; k < 2; k++) begin
        if (c_if.wake[k] && $urandom_range(0, 2) == 0) begin
          c_if.ack[k] = 1'b1;
          synced[k] = 1'b0;
        end else if (!synced[k] && c_if.wake == 2'b00 && !p_if.ack[0] &&
                     $urandom_range(0, 7) == 0) begin
          csync(k, int'($urandom_range(0, 3)));
          synced[k] = 1'b1;
        end else if ($urandom_range(0, 1499) == 0) begin
          csync(k, int'($urandom_range(0, 3)));
        end else if ($urandom_range(0, 1499) == 0) begin
          c_if.ack[k] = 1'b1;
        end
      end
      if (p_if.sync[0]) upcnt = int'($urandom_range(1, 6));
      else if (upcnt > 0) begin
        upcnt--;
        if (upcnt == 0) begin
          p_if.wake = 1'b1;
          p_if.error = 1'($urandom_range(0, 1));
          upcnt = -1;
        end
      end else if ($urandom_range(0, 1499) == 0) p_if.wake = 1'b1;
    end
    ticks(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fractal_sync_node.md
# fractal_sync_node

Two-child barrier node of the fractal synchronization tree, sitting directly downstream of each tile's fractal sync Xif decoder (one child port per decoder, or per lower node). It collects one sync request from each child. If the requested level equals this node's level, it releases both children locally; otherwise it forwards a single aggregated request to its parent and releases both children when the parent wakes it. The child-side protocol matches the decoder's fractal master port exactly: a 1-cycle `sync` pulse with `level`, then a wait for `wake`, then a 1-cycle `ack`.

## Interface
- LVL_W, default redmule_tile_pkg::FSYNC_LVL_W: width of the level field.
- NODE_LVL, default 1: level at which this node is the barrier point; must be ≥1 and < 2^LVL_W.
- TOP, default 0: 1 means the node has no parent; parent outputs are tied to 0 and parent inputs are ignored.
- clk_i  in  1  single clock for the whole block.
- rst_i  in  1  reset; synchronous, active-high.
- c_sync_i  in  2  per-child 1-cycle sync request.
- c_level_i  in  2×LVL_W  per-child requested level, valid only with c_sync_i.
- c_ack_i  in  2  per-child 1-cycle acknowledge of wake.
- c_wake_o  out  2  per-child wake; held high until that child acks.
- c_error_o  out  2  per-child error; valid while c_wake_o is high.
- p_sync_o  out  1  1-cycle sync pulse to the parent.
- p_level_o  out  LVL_W  level forwarded to the parent; nonzero only while p_sync_o is high.
- p_ack_o  out  1  1-cycle acknowledge to the parent.
- p_wake_i  in  1  parent wake.
- p_error_i  in  1  parent error, sampled together with p_wake_i.
- proto_err_o  out  1  sticky protocol-violation flag; cleared only by rst_i.

## Operation
- The FSM has states IDLE, UP_REQ, UP_WAIT, WAKE and UP_ACK. Each child has a pending flag, a latched level, and an acked flag.
- IDLE:
  - c_sync_i[k] with pend[k]=0 sets pend[k] and latches lvl[k].
  - If both children sync in the same cycle, both are latched.
- IDLE evaluation uses the registered flags only, and runs when pend==2'b11:
  - Illegal request: lvl[0]≠lvl[1], or lvl==0, or lvl<NODE_LVL, or (lvl>NODE_LVL and TOP=1). Set err=1, go to WAKE, up=0.
  - lvl==NODE_LVL: set err=0, go to WAKE, up=0.
  - lvl>NODE_LVL with TOP=0: go to UP_REQ, up=1.
- UP_REQ: assert p_sync_o=1 and p_level_o=lvl[0] for exactly one cycle, then go to UP_WAIT.
- UP_WAIT: hold until p_wake_i=1, then set err=p_error_i and go to WAKE.
- WAKE:
  - c_wake_o[k]=~acked[k] and c_error_o[k]=err&~acked[k].
  - c_ack_i[k] sets acked[k].
  - When both children have acked (either in the same cycle or in different cycles), clear pend, acked and err, then go to UP_ACK if up=1, else IDLE.
- UP_ACK: assert p_ack_o=1 for one cycle, then go to IDLE.
- Protocol violations set proto_err_o and the offending input is otherwise ignored:
  - c_sync_i[k] while pend[k]=1 or while state≠IDLE.
  - c_ack_i[k] while c_wake_o[k]=0.
  - p_wake_i in any state other than UP_WAIT.
- All outputs are Moore outputs, decoded from registered state only.

## Timing
- Reset: state=IDLE; pend, acked, err, up and proto_err_o are all 0; every output is 0.
- Reset mid-operation drops all pending requests. No wake or ack is issued afterwards.
- Local barrier, with the later child sync in cycle t:
  - pend==11 is visible at t+1.
  - c_wake_o goes high at t+2.
  - A decoder child acks at t+3, and its wake drops at t+4.
- Up path, with the later child sync in cycle t:
  - p_sync_o is high at t+2.
  - UP_WAIT is entered at t+3.
  - p_wake_i at cycle w gives c_wake_o high at w+1.
  - If the last child ack is at cycle a, p_ack_o is high at a+1 and the node is back in IDLE at a+2.
- Throughput: a new child sync is accepted in the first cycle the FSM is back in IDLE.
- Requests from the two children may be separated by an arbitrary number of cycles; there is no timeout.

## Test plan
- Local barrier (NODE_LVL=1): c0 syncs with level 1 at cycle 10, c1 syncs with level 1 at cycle 15 → c_wake_o=2'b11 at cycle 17, c_error_o=0, p_sync_o never asserted. Ack both at 18 → wake=0 at 19, node in IDLE.
- Simultaneous up request (NODE_LVL=1, TOP=0): both children sync with level 2 at cycle 5 → p_sync_o=1 with p_level_o=2 at cycle 7 only. Parent wake at 12 → c_wake_o=11 at 13. Acks at 14 and 16 → c_wake_o=10 at 15, 00 at 17; p_ack_o=1 at 17.
- Parent error propagation: repeat the up request with p_error_i=1 alongside p_wake_i → c_error_o=11 for as long as each child's wake is high; it clears after the acks.
- Illegal levels: levels 1 and 2 (mismatch), level 0, and level 2 with TOP=1 → c_wake_o=11 with c_error_o=11 at t+2, and no p_sync_o.
- Protocol violations: c0 syncs twice before c1 syncs, and a spurious c_ack_i[1] arrives in IDLE → proto_err_o=1 and stays 1. The later normal barrier still completes with correct timing.
- Reset during UP_WAIT: rst_i=1 for one cycle → all outputs 0 next cycle. A p_wake_i arriving afterwards produces no child wake and sets proto_err_o. A fresh barrier then works.
